apb_controller: RTL and testbench



---
 rtl/apb_bridge_pkg.sv | 30 +++
 rtl/apb_controller_if.sv | 38 +++
 rtl/apb_wait_timer.sv | 46 ++++
 rtl/apb_controller.sv | 148 ++++++++++++++
 tb/tb_apb_controller.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_bridge_pkg.sv
// ============================================================================
// apb_bridge_pkg : shared encodings and APB window bounds for the AHB-APB bridge
// Rev 1.0
// ============================================================================
`default_nettype none

package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WWAIT   = 3'd1,
    ST_RSETUP  = 3'd2,
    ST_RENABLE = 3'd3,
    ST_WSETUP  = 3'd4,
    ST_WENABLE = 3'd5
  } apb_state_e;

  localparam logic [2:0] SEL_P0 = 3'b001;
  localparam logic [2:0] SEL_P1 = 3'b010;
  localparam logic [2:0] SEL_P2 = 3'b100;

  // Peripheral windows: P0 [BASE_P0, BASE_P1), P1 [BASE_P1, BASE_P2), P2 [BASE_P2, WIN_END)
  localparam logic [31:0] APB_BASE_P0 = 32'h8000_0000;
  localparam logic [31:0] APB_BASE_P1 = 32'h8400_0000;
  localparam logic [31:0] APB_BASE_P2 = 32'h8800_0000;
  localparam logic [31:0] APB_WIN_END = 32'h8C00_0000;

endpackage : apb_bridge_pkg

`default_nettype wire

// File: rtl/apb_controller_if.sv
// ============================================================================
// apb_controller_if : decoded AHB request, APB bus and AHB ready for apb_controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface apb_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              hwrite;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic [2:0]        temp_selx;
  logic              pready;
  logic [2:0]        pselx;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              hreadyout;
  logic              apb_timeout;

  // Controller view: it masters the APB side.
  modport master (
    input  valid, hwrite, haddr, hwdata, temp_selx, pready,
    output pselx, penable, pwrite, paddr, pwdata, hreadyout, apb_timeout
  );

  // Environment view: AHB request source and APB completer.
  modport slave (
    output valid, hwrite, haddr, hwdata, temp_selx, pready,
    input  pselx, penable, pwrite, paddr, pwdata, hreadyout, apb_timeout
  );
endinterface : apb_controller_if

`default_nettype wire

// File: rtl/apb_wait_timer.sv
// ============================================================================
// apb_wait_timer : counts ENABLE cycles with pready low and flags the limit cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_wait_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  wire logic hclk,
  input  wire logic hreset,
  input  wire logic in_enable,
  input  wire logic pready,
  output logic      timeout_hit
);

  localparam logic [7:0] c_limit_m1 = 8'(WAIT_LIMIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // pready takes priority: the limit cycle with pready high is a normal completion.
  assign timeout_hit = in_enable & ~pready & (cnt_q == c_limit_m1);

  always_comb begin
    cnt_d = cnt_q;
    if (in_enable) begin
      if (pready || timeout_hit) begin
        cnt_d = 8'd0;
      end else if (cnt_q != c_limit_m1) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : apb_wait_timer

`default_nettype wire

// File: rtl/apb_controller.sv
// ============================================================================
// apb_controller : APB-side master FSM of the AHB-to-APB bridge
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_controller
  import apb_bridge_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input wire logic          hclk,
  input wire logic          hreset,
  apb_controller_if.master  bus
);

  apb_state_e        state_q,   state_d;
  logic [2:0]        pselx_q,   pselx_d;
  logic              penable_q, penable_d;
  logic              pwrite_q,  pwrite_d;
  logic [ADDR_W-1:0] paddr_q,   paddr_d;
  logic [DATA_W-1:0] pwdata_q,  pwdata_d;
  logic [ADDR_W-1:0] addr_r_q,  addr_r_d;
  logic [2:0]        sel_r_q,   sel_r_d;

  logic in_enable;
  logic timeout_hit;
  logic done;

  assign in_enable = (state_q == ST_RENABLE) || (state_q == ST_WENABLE);
  assign done      = in_enable & (bus.pready | timeout_hit);

  apb_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .hclk        (hclk),
    .hreset      (hreset),
    .in_enable   (in_enable),
    .pready      (bus.pready),
    .timeout_hit (timeout_hit)
  );

  always_comb begin
    state_d   = state_q;
    pselx_d   = pselx_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    addr_r_d  = addr_r_q;
    sel_r_d   = sel_r_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.valid && !bus.hwrite) begin
          state_d  = ST_RSETUP;
          paddr_d  = bus.haddr;
          pselx_d  = bus.temp_selx;
          pwrite_d = 1'b0;
        end else if (bus.valid && bus.hwrite) begin
          state_d  = ST_WWAIT;
          addr_r_d = bus.haddr;
          sel_r_d  = bus.temp_selx;
        end
      end

      // Write data arrives one cycle after the address, so it is captured here.
      ST_WWAIT: begin
        state_d  = ST_WSETUP;
        paddr_d  = addr_r_q;
        pselx_d  = sel_r_q;
        pwdata_d = bus.hwdata;
        pwrite_d = 1'b1;
      end

      ST_RSETUP: begin
        state_d   = ST_RENABLE;
        penable_d = 1'b1;
      end

      ST_WSETUP: begin
        state_d   = ST_WENABLE;
        penable_d = 1'b1;
      end

      ST_RENABLE, ST_WENABLE: begin
        if (done) begin
          penable_d = 1'b0;
          if (bus.valid && !bus.hwrite) begin
            state_d  = ST_RSETUP;
            paddr_d  = bus.haddr;
            pselx_d  = bus.temp_selx;
            pwrite_d = 1'b0;
          end else if (bus.valid && bus.hwrite) begin
            state_d  = ST_WWAIT;
            addr_r_d = bus.haddr;
            sel_r_d  = bus.temp_selx;
            pselx_d  = 3'b000;
          end else begin
            state_d  = ST_IDLE;
            pselx_d  = 3'b000;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        pselx_d   = 3'b000;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= ST_IDLE;
      pselx_q   <= 3'b000;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      addr_r_q  <= '0;
      sel_r_q   <= 3'b000;
    end else begin
      state_q   <= state_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      addr_r_q  <= addr_r_d;
      sel_r_q   <= sel_r_d;
    end
  end

  assign bus.pselx       = pselx_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.hreadyout   = (state_q == ST_IDLE) | done;
  assign bus.apb_timeout = timeout_hit;

endmodule : apb_controller

`default_nettype wire

// File: tb/tb_apb_controller.sv
// ============================================================================
// tb_apb_controller : directed self-checking bench for apb_controller
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_apb_controller;

  logic hclk;
  logic hreset;
  int   n_checks;
  int   n_errors;

  apb_controller_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_controller #(
    .WAIT_LIMIT (4),
    .ADDR_W     (32),
    .DATA_W     (32)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [31:0] addr, input logic [2:0] sel);
    bus.valid     = 1'b1;
    bus.hwrite    = wr;
    bus.haddr     = addr;
    bus.temp_selx = sel;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    hreset        = 1'b1;
    bus.valid     = 1'b0;
    bus.hwrite    = 1'b0;
    bus.haddr     = '0;
    bus.hwdata    = '0;
    bus.temp_selx = 3'b000;
    bus.pready    = 1'b0;

    // Reset state
    #3;
    chk("rst_pselx",   32'(bus.pselx),       32'd0);
    chk("rst_penable", 32'(bus.penable),     32'd0);
    chk("rst_pwrite",  32'(bus.pwrite),      32'd0);
    chk("rst_paddr",   bus.paddr,            32'd0);
    chk("rst_pwdata",  bus.pwdata,           32'd0);
    chk("rst_hready",  32'(bus.hreadyout),   32'd1);
    chk("rst_tmo",     32'(bus.apb_timeout), 32'd0);
    step();
    hreset = 1'b0;

    // Single read, pready high
    bus.pready = 1'b1;
    req(1'b0, 32'h8000_0010, 3'b001);
    step();
    bus.valid = 1'b0;
    #1;
    chk("rd_setup_psel",  32'(bus.pselx),     32'h1);
    chk("rd_setup_pen",   32'(bus.penable),   32'd0);
    chk("rd_setup_paddr", bus.paddr,          32'h8000_0010);
    chk("rd_setup_pwr",   32'(bus.pwrite),    32'd0);
    chk("rd_setup_hrdy",  32'(bus.hreadyout), 32'd0);
    step();
    chk("rd_en_pen",  32'(bus.penable),     32'd1);
    chk("rd_en_hrdy", 32'(bus.hreadyout),   32'd1);
    chk("rd_en_tmo",  32'(bus.apb_timeout), 32'd0);
    step();
    chk("rd_idle_psel",  32'(bus.pselx),     32'd0);
    chk("rd_idle_pen",   32'(bus.penable),   32'd0);
    chk("rd_idle_hrdy",  32'(bus.hreadyout), 32'd1);
    chk("rd_idle_paddr", bus.paddr,          32'h8000_0010);

    // Single write: hwdata follows one cycle after the address
    req(1'b1, 32'h8400_0004, 3'b010);
    step();
    bus.valid  = 1'b0;
    bus.haddr  = 32'h0000_0000;
    bus.hwdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_wait_hrdy", 32'(bus.hreadyout), 32'd0);
    chk("wr_wait_psel", 32'(bus.pselx),     32'd0);
    step();
    bus.hwdata = 32'h0000_0000;
    #1;
    chk("wr_setup_psel",  32'(bus.pselx),     32'h2);
    chk("wr_setup_pwr",   32'(bus.pwrite),    32'd1);
    chk("wr_setup_pwd",   bus.pwdata,         32'hDEAD_BEEF);
    chk("wr_setup_paddr", bus.paddr,          32'h8400_0004);
    chk("wr_setup_pen",   32'(bus.penable),   32'd0);
    chk("wr_setup_hrdy",  32'(bus.hreadyout), 32'd0);
    step();
    chk("wr_en_pen",  32'(bus.penable),   32'd1);
    chk("wr_en_hrdy", 32'(bus.hreadyout), 32'd1);
    step();
    chk("wr_idle_psel", 32'(bus.pselx), 32'd0);
    chk("wr_idle_pwd",  bus.pwdata,     32'hDEAD_BEEF);

    // Read with three wait states; the 4th ENABLE cycle coincides with the limit
    bus.pready = 1'b0;
    req(1'b0, 32'h8000_0030, 3'b100);
    step();
    bus.valid = 1'b0;
    #1;
    chk("ws_setup_psel", 32'(bus.pselx), 32'h4);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("ws_en%0d_pen", i),  32'(bus.penable),     32'd1);
      chk($sformatf("ws_en%0d_hrdy", i), 32'(bus.hreadyout),   32'd0);
      chk($sformatf("ws_en%0d_tmo", i),  32'(bus.apb_timeout), 32'd0);
    end
    step();
    bus.pready = 1'b1;
    #1;
    chk("ws_en4_pen",  32'(bus.penable),     32'd1);
    chk("ws_en4_hrdy", 32'(bus.hreadyout),   32'd1);
    chk("ws_en4_tmo",  32'(bus.apb_timeout), 32'd0);
    step();
    chk("ws_idle_pen", 32'(bus.penable), 32'd0);
    chk("ws_idle_pwd", bus.pwdata,       32'hDEAD_BEEF);

    // Timeout with pready stuck low
    bus.pready = 1'b0;
    req(1'b0, 32'h8000_0040, 3'b001);
    step();
    bus.valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("to_en%0d_hrdy", i), 32'(bus.hreadyout),   32'd0);
      chk($sformatf("to_en%0d_tmo", i),  32'(bus.apb_timeout), 32'd0);
    end
    step();
    chk("to_en4_tmo",  32'(bus.apb_timeout), 32'd1);
    chk("to_en4_hrdy", 32'(bus.hreadyout),   32'd1);
    chk("to_en4_pen",  32'(bus.penable),     32'd1);
    step();
    chk("to_idle_psel", 32'(bus.pselx),       32'd0);
    chk("to_idle_pen",  32'(bus.penable),     32'd0);
    chk("to_idle_tmo",  32'(bus.apb_timeout), 32'd0);
    chk("to_idle_hrdy", 32'(bus.hreadyout),   32'd1);

    // Back-to-back write then read with valid held
    bus.pready = 1'b1;
    req(1'b1, 32'h8800_0000, 3'b100);
    step();
    bus.hwdata = 32'h1234_5678;
    req(1'b0, 32'h8000_0020, 3'b001);
    #1;
    chk("bb_wait_hrdy", 32'(bus.hreadyout), 32'd0);
    step();
    chk("bb_wsetup_psel", 32'(bus.pselx),  32'h4);
    chk("bb_wsetup_pwd",  bus.pwdata,      32'h1234_5678);
    step();
    chk("bb_wen_pen",  32'(bus.penable),   32'd1);
    chk("bb_wen_hrdy", 32'(bus.hreadyout), 32'd1);
    chk("bb_wen_psel", 32'(bus.pselx),     32'h4);
    step();
    bus.valid = 1'b0;
    #1;
    chk("bb_rsetup_psel",  32'(bus.pselx),     32'h1);
    chk("bb_rsetup_pen",   32'(bus.penable),   32'd0);
    chk("bb_rsetup_pwr",   32'(bus.pwrite),    32'd0);
    chk("bb_rsetup_paddr", bus.paddr,          32'h8000_0020);
    chk("bb_rsetup_hrdy",  32'(bus.hreadyout), 32'd0);
    step();
    chk("bb_ren_pen",  32'(bus.penable),   32'd1);
    chk("bb_ren_hrdy", 32'(bus.hreadyout), 32'd1);
    step();
    chk("bb_idle_psel", 32'(bus.pselx), 32'd0);

    // Asynchronous reset in the middle of WENABLE
    bus.pready = 1'b0;
    req(1'b1, 32'h8400_0008, 3'b010);
    step();
    bus.valid  = 1'b0;
    bus.hwdata = 32'hCAFE_F00D;
    step();
    step();
    chk("mr_wen_pen",  32'(bus.penable), 32'd1);
    chk("mr_wen_psel", 32'(bus.pselx),   32'h2);
    #2;
    hreset = 1'b1;
    #1;
    chk("mr_psel",  32'(bus.pselx),       32'd0);
    chk("mr_pen",   32'(bus.penable),     32'd0);
    chk("mr_hrdy",  32'(bus.hreadyout),   32'd1);
    chk("mr_pwr",   32'(bus.pwrite),      32'd0);
    chk("mr_paddr", bus.paddr,            32'd0);
    step();
    hreset = 1'b0;
    step();
    chk("mr_idle_hrdy", 32'(bus.hreadyout), 32'd1);
    chk("mr_idle_psel", 32'(bus.pselx),     32'd0);

    // Controller accepts a new read after the reset
    bus.pready = 1'b1;
    req(1'b0, 32'h8000_0044, 3'b001);
    step();
    bus.valid = 1'b0;
    #1;
    chk("mr_rd_psel",  32'(bus.pselx), 32'h1);
    chk("mr_rd_paddr", bus.paddr,      32'h8000_0044);
    step();
    chk("mr_rd_hrdy", 32'(bus.hreadyout), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_apb_controller

`default_nettype wire
